l2_control_nway: RTL
====================

// Module: l2_control_nway
// PURPOSE
//  N-way, write-back L2 cache controller FSM. Parametrised successor of the 2-way L2 controller.
//  Sits between the L1/arbiter request port and physical memory.
//  Drives the L2 datapath (way select, array read/write, dirty, LRU).
//  Adds: victim choice, optional no-write-allocate bypass, pmem timeout/error, hit/miss counters.
// PARAMETERS
//  WAYS            4    associativity; power of two, >=2
//  WAY_W           $clog2(WAYS)  way index width (derived; do not override)
//  WRITE_ALLOCATE  1    1: write miss fills the line; 0: write miss goes straight to pmem (bypass)
//  PMEM_TIMEOUT    255  cycles waiting for pmem_resp before error; 0 disables the timeout
//  STAT_W          16   width of the hit/miss counters
// PORTS
//  clk             in   1       clock, rising edge
//  rst             in   1       asynchronous, active-low reset
//  mem_read        in   1       CPU-side read request, held until mem_resp
//  mem_write       in   1       CPU-side write request, held until mem_resp
//  mem_resp        out  1       one-cycle completion pulse
//  mem_error       out  1       qualifies mem_resp: request aborted by pmem timeout
//  hit_vec         in   WAYS    per-way tag match AND valid, for the current set
//  valid_vec       in   WAYS    per-way valid bits, for the current set
//  dirty_vec       in   WAYS    per-way dirty bits, for the current set
//  lru_way         in   WAY_W   LRU way of the current set
//  way_sel         out  WAY_W   way addressed by cache_read / cache_write / dirty ops
//  cache_read      out  1       data-array read enable
//  cache_write     out  1       data-array write enable (line fill or CPU write)
//  from_processor  out  1       write data/mask from CPU (1) or from pmem line (0)
//  wb_addr_sel     out  1       pmem address = victim tag + set (1) or CPU address (0)
//  set_dirty       out  1       set dirty bit of way_sel
//  clr_dirty       out  1       clear dirty bit of way_sel
//  lru_update      out  1       mark way_sel most-recently-used
//  pmem_read       out  1       pmem line read, held until pmem_resp
//  pmem_write      out  1       pmem line/word write, held until pmem_resp
//  pmem_resp       in   1       pmem completion pulse
//  hit_count       out  STAT_W  saturating count of first-lookup hits
//  miss_count      out  STAT_W  saturating count of first-lookup misses
// BEHAVIOUR
//  Reset (rst=0, any cycle, async):
//   - state<=IDLE; victim, refill flag, timeout counter and hit/miss counters <=0.
//   - All other outputs 0 while reset is held. Aborts any pmem transaction in progress.
//  Outputs are combinational from state and inputs; defaults are 0.
//  Request: mem_read|mem_write. If both are high, it is treated as a write.
//  States:
//   IDLE: outputs idle.
//    - request -> TAG_CHK; clear refill flag.
//   TAG_CHK: cache_read=1. hit = |hit_vec; hit way = lowest set index.
//    - request dropped -> IDLE, no resp, no count.
//    - read hit: way_sel=hit way, mem_resp, lru_update -> IDLE.
//    - write hit: also cache_write, from_processor, set_dirty -> IDLE.
//    - miss: latch victim = lowest invalid way, else lru_way.
//      - victim valid&dirty -> WB.
//      - else write with WRITE_ALLOCATE=0 -> BYPASS.
//      - else -> FILL.
//    - hit_count/miss_count increment here only when refill flag=0; saturate at all-ones.
//   WB: pmem_write, cache_read, wb_addr_sel=1, way_sel=victim.
//    - On pmem_resp -> FILL.
//   FILL: pmem_read, way_sel=victim.
//    - On pmem_resp: cache_write, clr_dirty; set refill flag -> TAG_CHK.
//    - The re-lookup hits, so a fill miss responds at TAG_CHK.
//   BYPASS: pmem_write, from_processor.
//    - On pmem_resp: mem_resp -> IDLE. No array, LRU or dirty change.
//   ERR: mem_resp=1, mem_error=1 for one cycle -> IDLE.
//  Latency:
//   - Hit: mem_resp in the cycle after the request is seen in IDLE (2 cycles total).
//   - Clean miss: 2 + pmem + 1 cycles.
//   - Dirty miss adds the writeback time.
//  Timeout:
//   - Counter clears on entry to WB/FILL/BYPASS and increments each cycle without pmem_resp.
//   - When it reaches PMEM_TIMEOUT (nonzero): drop pmem strobe that cycle -> ERR.
//   - pmem_resp in the same cycle as timeout expiry wins (normal path).
//  Victim is stable from miss detection until FILL completes; the CPU address must be held.
// TESTING
//  1. Read, hit_vec=4'b0100 -> TAG_CHK next cycle, way_sel=2, mem_resp+lru_update same cycle; hit_count=1.
//  2. Read miss, valid=4'b1111, dirty=4'b0010, lru_way=1 -> WB way1, pmem_resp@+3 -> FILL, pmem_resp -> clr_dirty; re-hit resp; miss_count=1, hit_count=0.
//  3. WRITE_ALLOCATE=0, write miss -> BYPASS pmem_write+from_processor; pmem_resp -> mem_resp, cache_write never 1.
//  4. PMEM_TIMEOUT=8, read miss, no pmem_resp -> pmem_read drops after 8 cycles; mem_resp+mem_error pulse; IDLE.
//  5. rst=0 asynchronously mid-FILL -> pmem_read=0 immediately, counters 0; after release, read hit works normally.
//  6. Force hit_count to 16'hFFFF, then one more hit -> stays 16'hFFFF; also test mem_read&mem_write both high -> write path.

Source files
------------

// File: rtl/l2_control_nway.sv
// N-way write-back L2 cache controller FSM.
// Drives way select, array read/write, dirty and LRU strobes of the L2
// datapath. Sequences writeback and refill against physical memory, or
// bypasses a write miss straight to pmem when write-allocate is off.
// A pmem request that never completes is aborted with mem_error.
module l2_control_nway #(
  parameter int WAYS           = 4,
  parameter int WAY_W          = $clog2(WAYS),
  parameter int WRITE_ALLOCATE = 1,
  parameter int PMEM_TIMEOUT   = 255,
  parameter int STAT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic              mem_resp,
  output logic              mem_error,
  input  logic [WAYS-1:0]   hit_vec,
  input  logic [WAYS-1:0]   valid_vec,
  input  logic [WAYS-1:0]   dirty_vec,
  input  logic [WAY_W-1:0]  lru_way,
  output logic [WAY_W-1:0]  way_sel,
  output logic              cache_read,
  output logic              cache_write,
  output logic              from_processor,
  output logic              wb_addr_sel,
  output logic              set_dirty,
  output logic              clr_dirty,
  output logic              lru_update,
  output logic              pmem_read,
  output logic              pmem_write,
  input  logic              pmem_resp,
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count
);

  localparam int TMO_W = (PMEM_TIMEOUT > 0) ? $clog2(PMEM_TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(PMEM_TIMEOUT);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] TAG_CHK = 3'd1;
  localparam logic [2:0] WB      = 3'd2;
  localparam logic [2:0] FILL    = 3'd3;
  localparam logic [2:0] BYPASS  = 3'd4;
  localparam logic [2:0] ERR     = 3'd5;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [WAY_W-1:0] victim;
  logic             refill;
  logic [TMO_W-1:0] tmo_cnt;

  logic             req;
  logic             any_hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim_pick;
  logic             victim_dirty;
  logic             expired;
  logic             in_pmem;

  assign req     = mem_read | mem_write;
  assign any_hit = |hit_vec;
  assign in_pmem = (state == WB) || (state == FILL) || (state == BYPASS);
  // A response arriving in the expiry cycle still completes normally.
  assign expired = (PMEM_TIMEOUT != 0) && (tmo_cnt == TMO_LIMIT) && !pmem_resp;

  // Hit way and victim are both the lowest qualifying index; victim falls back to LRU.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise an incomplete path infers a latch.
    hit_way     = '0;
    victim_pick = lru_way;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i])    hit_way     = WAY_W'(i);
      if (!valid_vec[i]) victim_pick = WAY_W'(i);
    end
    victim_dirty = valid_vec[victim_pick] & dirty_vec[victim_pick];
  end

  // Next state and datapath strobes; everything idles at 0 unless a state asserts it.
  always_comb begin
    state_next     = state;
    mem_resp       = 1'b0;
    mem_error      = 1'b0;
    way_sel        = '0;
    cache_read     = 1'b0;
    cache_write    = 1'b0;
    from_processor = 1'b0;
    wb_addr_sel    = 1'b0;
    set_dirty      = 1'b0;
    clr_dirty      = 1'b0;
    lru_update     = 1'b0;
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    case (state)
      IDLE: if (req) state_next = TAG_CHK;
      TAG_CHK: begin
        cache_read = 1'b1;
        if (!req) begin
          state_next = IDLE;
        end else if (any_hit) begin
          way_sel    = hit_way;
          mem_resp   = 1'b1;
          lru_update = 1'b1;
          if (mem_write) begin
            cache_write    = 1'b1;
            from_processor = 1'b1;
            set_dirty      = 1'b1;
          end
          state_next = IDLE;
        end else if (victim_dirty) begin
          state_next = WB;
        end else if (mem_write && (WRITE_ALLOCATE == 0)) begin
          state_next = BYPASS;
        end else begin
          state_next = FILL;
        end
      end
      WB: begin
        way_sel     = victim;
        cache_read  = 1'b1;
        wb_addr_sel = 1'b1;
        pmem_write  = !expired;
        if (pmem_resp)    state_next = FILL;
        else if (expired) state_next = ERR;
      end
      FILL: begin
        way_sel   = victim;
        pmem_read = !expired;
        if (pmem_resp) begin
          cache_write = 1'b1;
          clr_dirty   = 1'b1;
          state_next  = TAG_CHK;
        end else if (expired) begin
          state_next = ERR;
        end
      end
      BYPASS: begin
        from_processor = 1'b1;
        pmem_write     = !expired;
        if (pmem_resp) begin
          mem_resp   = 1'b1;
          state_next = IDLE;
        end else if (expired) begin
          state_next = ERR;
        end
      end
      ERR: begin
        mem_resp   = 1'b1;
        mem_error  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, latched victim, refill flag and pmem timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state   <= IDLE;
      victim  <= '0;
      refill  <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == TAG_CHK && req && !any_hit) victim <= victim_pick;
      if (state == IDLE && req)                refill <= 1'b0;
      else if (state == FILL && pmem_resp)     refill <= 1'b1;
      if (state_next != state)
        tmo_cnt <= '0;
      else if (in_pmem && !pmem_resp && (PMEM_TIMEOUT != 0) && tmo_cnt != TMO_LIMIT)
        tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Saturating first-lookup statistics; re-lookups after a refill are not counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == TAG_CHK && req && !refill) begin
      if (any_hit) begin
        if (hit_count != '1) hit_count <= hit_count + STAT_W'(1);
      end else begin
        if (miss_count != '1) miss_count <= miss_count + STAT_W'(1);
      end
    end
  end

endmodule
